game_state_controller: RTL
==========================

Name: game_state_controller

Overview:
- Parametrised successor to the top-level game state logic: owns lives, level, start/respawn/game-over sequencing and frog facing direction.
- Sits between the switch inputs, the collision detector and the character/obstacle/display blocks.
- Adds four things the previous two-state controller lacked: start-hold qualification, a post-hit invulnerability window, a timed game-over screen, and level tracking with bonus lives.

Parameters:
- START_LIVES, 3: lives loaded on game start and on reset.
- MAX_LIVES, 5: life saturation ceiling; also the LED vector width.
- LIFE_W, $clog2(MAX_LIVES+1): lives counter width.
- START_HOLD_CYCLES, 4: consecutive cycles all switches must be high to start.
- INVULN_CYCLES, 8: length of the RESPAWN window (collisions ignored).
- GAME_OVER_CYCLES, 16: cycles spent in GAME_OVER before returning to IDLE.
- MAX_LEVEL, 15: level saturation value.
- LEVEL_W, 4: level counter width.
- EXTRA_LIFE_EVERY, 2: a bonus life is granted when the new level is a nonzero multiple of this value; 0 disables bonus lives.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  synchronous active-high reset
- i_Switch  in  4  [0]=up, [1]=left, [2]=right, [3]=down
- i_Has_Collided  in  1  collision level from the collision detector
- i_Level_Up  in  1  one-cycle pulse when the frog reaches the far side
- o_Game_Active  out  1  high in RUNNING and RESPAWN
- o_State  out  2  IDLE=0, RUNNING=1, RESPAWN=2, GAME_OVER=3
- o_Lives  out  LIFE_W  current life count
- o_Life_LEDs  out  MAX_LIVES  thermometer code; bit i = (o_Lives > i)
- o_Level  out  LEVEL_W  current level
- o_Respawn  out  1  one-cycle pulse on each life loss that does not end the game
- o_Frog_Direction  out  2  0=up, 1=left, 2=right, 3=down

Behaviour:
- Reset (synchronous, i_Reset=1 at posedge):
  - State=IDLE, lives=START_LIVES, level=0, direction=0.
  - All counters are zeroed, o_Respawn=0 and the collision history register=0.
  - Reset overrides every other event in the same cycle, including mid-RESPAWN and mid-GAME_OVER.
- Collision edge:
  - col_edge = i_Has_Collided & ~prev; prev registers i_Has_Collided every cycle in every state.
  - A collision held high across RESPAWN→RUNNING therefore does not count again.
- IDLE:
  - The hold counter increments while i_Switch==4'b1111 and clears when any switch is low.
  - When the counter reaches START_HOLD_CYCLES-1 with all switches still high: go to RUNNING next cycle, lives=START_LIVES, level=0, counter cleared.
  - Collisions and level-ups are ignored.
- RUNNING:
  - On col_edge with lives>1: lives-=1, o_Respawn=1 for 1 cycle, go to RESPAWN, load the timer with INVULN_CYCLES-1.
  - On col_edge with lives==1: lives=0, go to GAME_OVER, load the timer with GAME_OVER_CYCLES-1.
  - On i_Level_Up: level=min(level+1, MAX_LEVEL). If bonus lives are enabled and the new level is a multiple of EXTRA_LIFE_EVERY, lives=min(lives+1, MAX_LIVES).
  - At MAX_LEVEL the level holds and no further bonus is granted.
- Simultaneous col_edge and i_Level_Up: collision handling applies, the level still increments, and the bonus life is suppressed.
- RESPAWN:
  - col_edge is ignored; i_Level_Up is handled exactly as in RUNNING.
  - The timer decrements each cycle; at timer==0 go to RUNNING next cycle.
  - Total time in RESPAWN is exactly INVULN_CYCLES cycles.
- GAME_OVER:
  - All inputs except reset are ignored, including all-switch presses.
  - The timer counts down; at 0 go to IDLE. Lives stay 0 until the next start; level is frozen for display.
- Direction (all states):
  - Priority up > left > right > down among high switches.
  - With no switch high and col_edge, direction=0; otherwise hold.
- Output timing: all outputs are registered; 1-cycle latency from input to output.

Decomposition:
- Constants.v additions: state encodings IDLE/RUNNING/RESPAWN/GAME_OVER and direction encodings DIR_UP/LT/RT/DN.
- Parameter defaults are added to Constants.v as global constants, alongside the existing TILE_SIZE etc.
- One sub-module, state_timer:
  - Loadable down-counter: i_Clk, i_Reset, i_Load, i_Value, o_Zero.
  - Width $clog2(max(INVULN_CYCLES, GAME_OVER_CYCLES)).
  - Shared by RESPAWN and GAME_OVER.

Test Plan:
- Start hold: reset, then switches=1111 for 3 cycles, drop for 1, then 1111 for 4 → o_State=RUNNING only after the second run's 4th cycle; o_Lives=3, o_Life_LEDs=5'b00111.
- Hit and invulnerability: RUNNING, collision high for 20 cycles → lives 3→2 once, o_Respawn one pulse, o_State=RESPAWN for exactly 8 cycles, then RUNNING with no further decrement.
- Game over: three separated collision pulses → lives 3,2,1,0; GAME_OVER for 16 cycles with switches=1111 held throughout (ignored), then IDLE; LEDs=00000.
- Levels and bonus: 4 level-up pulses in RUNNING, lives=3 → levels 1..4, lives 4 at level 2 and 5 at level 4; a 6th pulse at level 6 keeps lives=5 (saturation).
- Simultaneous events: col_edge and i_Level_Up in the same cycle at level 1, lives 3 → level=2, lives=2, no bonus, RESPAWN entered.
- Reset mid-state: assert i_Reset during RESPAWN (timer=4) and again during GAME_OVER → next cycle IDLE, lives=3, level=0, o_Respawn=0, direction=0.

Source files
------------

// File: rtl/game_state_controller_pkg.sv
// Shared encodings and parameter defaults for the frog game state controller.
package game_state_controller_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUNNING   = 2'd1,
      RESPAWN   = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   localparam logic [1:0] DIR_UP = 2'd0;
   localparam logic [1:0] DIR_LT = 2'd1;
   localparam logic [1:0] DIR_RT = 2'd2;
   localparam logic [1:0] DIR_DN = 2'd3;

   localparam int DEF_START_LIVES       = 3;
   localparam int DEF_MAX_LIVES         = 5;
   localparam int DEF_START_HOLD_CYCLES = 4;
   localparam int DEF_INVULN_CYCLES     = 8;
   localparam int DEF_GAME_OVER_CYCLES  = 16;
   localparam int DEF_MAX_LEVEL         = 15;
   localparam int DEF_LEVEL_W           = 4;
   localparam int DEF_EXTRA_LIFE_EVERY  = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_state_controller_state_timer.sv
// Loadable down-counter shared by the RESPAWN and GAME_OVER windows.
module state_timer #(
   parameter int WIDTH = 4
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Load,
   input  logic [WIDTH-1:0] i_Value,
   output logic             o_Zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge i_Clk) begin
      if (i_Reset)
         count <= '0;
      else if (i_Load)
         count <= i_Value;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign o_Zero = (count == '0);

endmodule

// File: rtl/game_state_controller.sv
// Game sequencing: start qualification, lives, levels/bonus lives, respawn
// invulnerability, timed game-over screen and frog facing direction.
module game_state_controller
   import game_state_controller_pkg::*;
#(
   parameter int START_LIVES       = DEF_START_LIVES,
   parameter int MAX_LIVES         = DEF_MAX_LIVES,
   parameter int LIFE_W            = $clog2(MAX_LIVES + 1),
   parameter int START_HOLD_CYCLES = DEF_START_HOLD_CYCLES,
   parameter int INVULN_CYCLES     = DEF_INVULN_CYCLES,
   parameter int GAME_OVER_CYCLES  = DEF_GAME_OVER_CYCLES,
   parameter int MAX_LEVEL         = DEF_MAX_LEVEL,
   parameter int LEVEL_W           = DEF_LEVEL_W,
   parameter int EXTRA_LIFE_EVERY  = DEF_EXTRA_LIFE_EVERY
) (
   input  logic               i_Clk,
   input  logic               i_Reset,
   input  logic [3:0]         i_Switch,
   input  logic               i_Has_Collided,
   input  logic               i_Level_Up,
   output logic               o_Game_Active,
   output logic [1:0]         o_State,
   output logic [LIFE_W-1:0]  o_Lives,
   output logic [MAX_LIVES-1:0] o_Life_LEDs,
   output logic [LEVEL_W-1:0] o_Level,
   output logic               o_Respawn,
   output logic [1:0]         o_Frog_Direction
);

   localparam int TIMER_W   = max_int($clog2(max_int(INVULN_CYCLES, GAME_OVER_CYCLES)), 1);
   localparam int HOLD_W    = max_int($clog2(START_HOLD_CYCLES + 1), 1);
   localparam int BONUS_DIV = (EXTRA_LIFE_EVERY == 0) ? 1 : EXTRA_LIFE_EVERY;

   state_t               state, state_nx;
   logic [LIFE_W-1:0]    lives, lives_nx;
   logic [LEVEL_W-1:0]   level, level_nx;
   logic [1:0]           dir, dir_nx;
   logic [HOLD_W-1:0]    hold, hold_nx;
   logic                 prev;
   logic                 respawn, respawn_nx;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_value;
   logic                 timer_zero;

   logic                 col_edge, all_sw, level_at_max, bonus_ok;
   logic [LEVEL_W-1:0]   level_inc;
   logic [LIFE_W-1:0]    lives_inc;

   assign col_edge     = i_Has_Collided & ~prev;
   assign all_sw       = (i_Switch == 4'b1111);
   assign level_at_max = (level == LEVEL_W'(MAX_LEVEL));
   assign level_inc    = level_at_max ? level : level + LEVEL_W'(1);
   assign lives_inc    = (lives == LIFE_W'(MAX_LIVES)) ? lives : lives + LIFE_W'(1);
   assign bonus_ok     = (EXTRA_LIFE_EVERY != 0) && !level_at_max &&
                         ((32'(level_inc) % BONUS_DIV) == 0);

   state_timer #(.WIDTH(TIMER_W)) u_timer (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Load  (timer_load),
      .i_Value (timer_value),
      .o_Zero  (timer_zero)
   );

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state   <= IDLE;
         lives   <= LIFE_W'(START_LIVES);
         level   <= '0;
         dir     <= DIR_UP;
         hold    <= '0;
         prev    <= 1'b0;
         respawn <= 1'b0;
      end else begin
         state   <= state_nx;
         lives   <= lives_nx;
         level   <= level_nx;
         dir     <= dir_nx;
         hold    <= hold_nx;
         prev    <= i_Has_Collided;
         respawn <= respawn_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      lives_nx    = lives;
      level_nx    = level;
      hold_nx     = '0;
      respawn_nx  = 1'b0;
      timer_load  = 1'b0;
      timer_value = '0;
      case (state)
         IDLE: begin
            if (all_sw) begin
               if (hold == HOLD_W'(START_HOLD_CYCLES - 1)) begin
                  state_nx = RUNNING;
                  lives_nx = LIFE_W'(START_LIVES);
                  level_nx = '0;
               end else begin
                  hold_nx = hold + HOLD_W'(1);
               end
            end
         end
         RUNNING: begin
            if (i_Level_Up) begin
               level_nx = level_inc;
               // a hit in the same cycle forfeits the bonus
               if (bonus_ok && !col_edge)
                  lives_nx = lives_inc;
            end
            if (col_edge) begin
               if (lives > LIFE_W'(1)) begin
                  lives_nx    = lives - LIFE_W'(1);
                  respawn_nx  = 1'b1;
                  state_nx    = RESPAWN;
                  timer_load  = 1'b1;
                  timer_value = TIMER_W'(INVULN_CYCLES - 1);
               end else begin
                  lives_nx    = '0;
                  state_nx    = GAME_OVER;
                  timer_load  = 1'b1;
                  timer_value = TIMER_W'(GAME_OVER_CYCLES - 1);
               end
            end
         end
         RESPAWN: begin
            if (i_Level_Up) begin
               level_nx = level_inc;
               if (bonus_ok)
                  lives_nx = lives_inc;
            end
            if (timer_zero)
               state_nx = RUNNING;
         end
         GAME_OVER: begin
            if (timer_zero)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      dir_nx = dir;
      if (i_Switch[0])      dir_nx = DIR_UP;
      else if (i_Switch[1]) dir_nx = DIR_LT;
      else if (i_Switch[2]) dir_nx = DIR_RT;
      else if (i_Switch[3]) dir_nx = DIR_DN;
      else if (col_edge)    dir_nx = DIR_UP;
   end

   assign o_State          = state;
   assign o_Game_Active    = (state == RUNNING) || (state == RESPAWN);
   assign o_Lives          = lives;
   assign o_Level          = level;
   assign o_Respawn        = respawn;
   assign o_Frog_Direction = dir;

   for (genvar i = 0; i < MAX_LIVES; i++) begin : g_led
      assign o_Life_LEDs[i] = (lives > LIFE_W'(i));
   end

endmodule
